// File: rtl/debounce_scan_arbiter.sv
// Time-multiplexed switch debouncer with a round-robin valid/ready event port.
// Optional interrupt output is built when DBNC_IRQ_EN is defined.
module debounce_scan_arbiter #(
  parameter int N_CH     = 4,
  parameter int N_BOUNCE = 3,
  parameter int TICK_DIV = 16,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] i_sig,
  output logic [N_CH-1:0] o_state,
  output logic            o_evt_valid,
  input  logic            i_evt_ready,
  output logic [CH_W-1:0] o_evt_ch,
  output logic            o_evt_rise,
  output logic            o_evt_ovf,
  input  logic            i_ovf_clr
`ifdef DBNC_IRQ_EN
  ,
  input  logic [N_CH-1:0] i_irq_mask,
  output logic            o_irq
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [N_BOUNCE-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]     sync1_q, s_q;
  logic [PW-1:0]       pre_q, pre_d;
  logic [CH_W-1:0]     sp_q, sp_d;
  logic [N_BOUNCE-1:0] cnt_q [N_CH];
  logic [N_BOUNCE-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]     state_q, state_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [N_CH-1:0]     prise_q, prise_d;
  logic                valid_q, valid_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                rise_q, rise_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic                ovf_q, ovf_d;

  logic                tick;
  logic                found;
  logic [CH_W-1:0]     pick;
  logic                ovf_set;
  int                  idx;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    pend_d  = pend_q;
    prise_d = prise_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    rise_d  = rise_q;
    gnt_d   = gnt_q;
    ovf_set = 1'b0;
    found   = 1'b0;
    pick    = '0;
    idx     = 0;

    // Round-robin search starts just after the last granted channel.
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(gnt_q) + k) % N_CH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end

    if (!valid_q || i_evt_ready) begin
      if (found) begin
        valid_d      = 1'b1;
        ch_d         = pick;
        rise_d       = prise_q[pick];
        gnt_d        = pick;
        pend_d[pick] = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end

    // The flip is applied after the load clear so a same-cycle set wins.
    if (tick) begin
      sp_d = (sp_q == CH_W'(N_CH - 1)) ? '0 : sp_q + CH_W'(1);
      if (s_q[sp_q] == state_q[sp_q]) begin
        cnt_d[sp_q] = '0;
      end else if (cnt_q[sp_q] != CNT_MAX) begin
        cnt_d[sp_q] = cnt_q[sp_q] + N_BOUNCE'(1);
      end else begin
        cnt_d[sp_q]   = '0;
        state_d[sp_q] = ~state_q[sp_q];
        ovf_set       = pend_d[sp_q];
        pend_d[sp_q]  = 1'b1;
        prise_d[sp_q] = ~state_q[sp_q];
      end
    end

    if (ovf_set)        ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= '0;
      s_q     <= '0;
      pre_q   <= '0;
      sp_q    <= '0;
      cnt_q   <= '{default: '0};
      state_q <= '0;
      pend_q  <= '0;
      prise_q <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rise_q  <= 1'b0;
      gnt_q   <= CH_W'(N_CH - 1);
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= i_sig;
      s_q     <= sync1_q;
      pre_q   <= pre_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      prise_q <= prise_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      rise_q  <= rise_d;
      gnt_q   <= gnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_state     = state_q;
  assign o_evt_valid = valid_q;
  assign o_evt_ch    = ch_q;
  assign o_evt_rise  = rise_q;
  assign o_evt_ovf   = ovf_q;

`ifdef DBNC_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= (|(pend_q & ~i_irq_mask)) | (valid_q & ~i_irq_mask[ch_q]);
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// Scoreboard bench for debounce_scan_arbiter: expected events are queued as
// inputs are driven and popped when the event port handshakes.
module tb_debounce_scan_arbiter;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int W    = CH_W + 1;

  logic            clk;
  logic            rstn;
  logic [N_CH-1:0] i_sig;
  logic [N_CH-1:0] o_state;
  logic            o_evt_valid;
  logic            i_evt_ready;
  logic [CH_W-1:0] o_evt_ch;
  logic            o_evt_rise;
  logic            o_evt_ovf;
  logic            i_ovf_clr;
`ifdef DBNC_IRQ_EN
  logic [N_CH-1:0] i_irq_mask;
  logic            o_irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  debounce_scan_arbiter #(.N_CH(4), .N_BOUNCE(3), .TICK_DIV(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_sig       (i_sig),
    .o_state     (o_state),
    .o_evt_valid (o_evt_valid),
    .i_evt_ready (i_evt_ready),
    .o_evt_ch    (o_evt_ch),
    .o_evt_rise  (o_evt_rise),
    .o_evt_ovf   (o_evt_ovf),
    .i_ovf_clr   (i_ovf_clr)
`ifdef DBNC_IRQ_EN
    ,
    .i_irq_mask  (i_irq_mask),
    .o_irq       (o_irq)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    exp_q.delete();
  endtask

  task automatic set_in(input int ch, input logic val);
    @(posedge clk); #1 i_sig[ch] = val;
  endtask

  task automatic set_ready(input logic val);
    @(posedge clk); #1 i_evt_ready = val;
  endtask

  task automatic wait_bit(input string tag, input int ch, input logic val);
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (o_state[ch] == val) break;
    end
    check(tag, int'(o_state[ch]), int'(val));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard monitor: event content and hold-while-stalled
  logic         prev_hold;
  logic [W:0]   prev_v;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold", int'({o_evt_valid, o_evt_ch, o_evt_rise}), int'(prev_v));
      if (o_evt_valid && i_evt_ready) begin
        if (exp_q.size() == 0) check("evt_expected", exp_q.size(), 1);
        else check("evt", int'({o_evt_ch, o_evt_rise}), int'(exp_q.pop_front()));
      end
      prev_hold = o_evt_valid && !i_evt_ready;
      prev_v    = {o_evt_valid, o_evt_ch, o_evt_rise};
    end
  end

  initial begin
    rstn        = 1'b0;
    i_sig       = '0;
    i_evt_ready = 1'b1;
    i_ovf_clr   = 1'b0;
`ifdef DBNC_IRQ_EN
    i_irq_mask  = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_state", int'(o_state), 0);
    check("rst_valid", int'(o_evt_valid), 0);
    check("rst_ch", int'(o_evt_ch), 0);
    check("rst_rise", int'(o_evt_rise), 0);
    check("rst_ovf", int'(o_evt_ovf), 0);

    // clean press on ch2
    set_in(2, 1'b1);
    exp_q.push_back({2'd2, 1'b1});
    wait_bit("press_state", 2, 1'b1);
    drain("press_drain");
    check("press_all_state", int'(o_state), 4);

    // bounce reject on ch1: about five differing samples, then back to 0
    set_in(1, 1'b1);
    repeat (320) @(posedge clk);
    #1 i_sig[1] = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    check("bounce_state", int'(o_state[1]), 0);
    check("bounce_no_evt", int'(o_evt_valid), 0);

    // arbitration with the consumer stalled
    set_ready(1'b0);
    set_in(0, 1'b1); exp_q.push_back({2'd0, 1'b1}); wait_bit("arb_ch0", 0, 1'b1);
    set_in(1, 1'b1); exp_q.push_back({2'd1, 1'b1}); wait_bit("arb_ch1", 1, 1'b1);
    set_in(3, 1'b1); exp_q.push_back({2'd3, 1'b1}); wait_bit("arb_ch3", 3, 1'b1);
    repeat (3) @(negedge clk);
    check("arb_present", int'({o_evt_valid, o_evt_ch, o_evt_rise}), int'({1'b1, 2'd0, 1'b1}));
    set_ready(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arb_b2b_valid", int'(o_evt_valid), 1);
    end
    @(negedge clk);
    check("arb_drop_valid", int'(o_evt_valid), 0);
    check("arb_q_empty", exp_q.size(), 0);

    // hold and overwrite
    i_sig = '0;
    do_reset();
    set_ready(1'b0);
    set_in(0, 1'b1); exp_q.push_back({2'd0, 1'b1}); wait_bit("ovw_ch0", 0, 1'b1);
    set_in(1, 1'b1); wait_bit("ovw_ch1_rise", 1, 1'b1);
    check("ovw_ovf_before", int'(o_evt_ovf), 0);
    set_in(1, 1'b0); exp_q.push_back({2'd1, 1'b0}); wait_bit("ovw_ch1_fall", 1, 1'b0);
    @(negedge clk);
    check("ovw_ovf_set", int'(o_evt_ovf), 1);
    check("ovw_present", int'({o_evt_valid, o_evt_ch, o_evt_rise}), int'({1'b1, 2'd0, 1'b1}));
    set_ready(1'b1);
    drain("ovw_drain");
    repeat (2) @(negedge clk);
    check("ovw_valid_idle", int'(o_evt_valid), 0);
    check("ovw_ovf_sticky", int'(o_evt_ovf), 1);
    @(posedge clk); #1 i_ovf_clr = 1'b1;
    @(posedge clk); #1 i_ovf_clr = 1'b0;
    @(negedge clk);
    check("ovw_ovf_clr", int'(o_evt_ovf), 0);

    // reset mid-operation
    set_ready(1'b0);
    set_in(2, 1'b1); exp_q.push_back({2'd2, 1'b1}); wait_bit("rmo_ch2", 2, 1'b1);
    set_in(3, 1'b1); exp_q.push_back({2'd3, 1'b1}); wait_bit("rmo_ch3", 3, 1'b1);
    @(negedge clk);
    check("rmo_valid_pre", int'(o_evt_valid), 1);
    i_sig = '0;
    do_reset();
    @(negedge clk);
    check("rmo_outputs", int'({o_state, o_evt_valid, o_evt_ch, o_evt_rise, o_evt_ovf}), 0);
    set_ready(1'b1);
    repeat (300) @(negedge clk);
    check("rmo_no_evt", int'(o_evt_valid), 0);
    check("rmo_state", int'(o_state), 0);

`ifdef DBNC_IRQ_EN
    i_irq_mask = 4'b0010;
    set_ready(1'b0);
    set_in(1, 1'b1); exp_q.push_back({2'd1, 1'b1}); wait_bit("irq_m_ch1", 1, 1'b1);
    repeat (3) @(negedge clk);
    check("irq_masked", int'(o_irq), 0);
    set_ready(1'b1);
    drain("irq_m_drain");
    check("irq_masked_after", int'(o_irq), 0);
    i_irq_mask = 4'b0000;
    set_ready(1'b0);
    set_in(2, 1'b1); exp_q.push_back({2'd2, 1'b1}); wait_bit("irq_u_ch2", 2, 1'b1);
    repeat (3) @(negedge clk);
    check("irq_on", int'(o_irq), 1);
    set_ready(1'b1);
    drain("irq_u_drain");
    repeat (2) @(negedge clk);
    check("irq_off", int'(o_irq), 0);
`endif

    check("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
